// File: rtl/source_arbiter.sv
// Round-robin arbiter sharing one NoC injection port between NUM_SRC sources.
// Optional per-source accept counters are enabled by defining SOURCE_ARB_STATS_EN.
module source_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned DATA_WIDTH = 500,
   parameter int unsigned DEST_WIDTH = 4,
   parameter int unsigned IDX_WIDTH  = $clog2(NUM_SRC)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable_in,
   input  logic [NUM_SRC*DATA_WIDTH-1:0]  req_data_in,
   input  logic [NUM_SRC*DEST_WIDTH-1:0]  req_dest_in,
   input  logic [NUM_SRC-1:0]             req_valid_in,
   output logic [NUM_SRC-1:0]             req_ready_out,
   output logic [DATA_WIDTH-1:0]          pkt_data_out,
   output logic [DEST_WIDTH-1:0]          pkt_dest_out,
   output logic                           pkt_valid_out,
   input  logic                           pkt_ready_in,
   output logic [IDX_WIDTH-1:0]           grant_idx_out,
   output logic [1:0]                     state_out,
   input  logic [IDX_WIDTH-1:0]           stat_sel_in,
   output logic [31:0]                    stat_count_out
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_DRAIN   = 2'b01,
      ST_STOPPED = 2'b10
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [IDX_WIDTH-1:0]   rr_ptr;
   logic                   transfer;
   logic                   slot_free;
   logic                   accept;
   logic                   win_found;
   logic [IDX_WIDTH-1:0]   win_idx;
   logic [IDX_WIDTH-1:0]   win_next;
   logic [DATA_WIDTH-1:0]  win_data;
   logic [DEST_WIDTH-1:0]  win_dest;

   assign transfer  = pkt_valid_out & pkt_ready_in;
   assign slot_free = ~pkt_valid_out | transfer;
   assign state_out = state;

   // Scan from the RR pointer upward with wrap; first valid source wins.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      win_next  = '0;
      win_data  = '0;
      win_dest  = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_SRC) cand = cand - NUM_SRC;
         if (!win_found && req_valid_in[cand]) begin
            win_found = 1'b1;
            win_idx   = IDX_WIDTH'(cand);
            win_next  = (cand == NUM_SRC - 1) ? '0 : IDX_WIDTH'(cand + 1);
            win_data  = req_data_in[cand*DATA_WIDTH +: DATA_WIDTH];
            win_dest  = req_dest_in[cand*DEST_WIDTH +: DEST_WIDTH];
         end
      end
   end

   // Accepts only in RUN with enable high; reset suppresses any ready pulse.
   assign accept = (state == ST_RUN) & enable_in & slot_free & win_found & ~reset;

   always_comb begin
      req_ready_out = '0;
      if (accept) req_ready_out[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (!enable_in) state_nxt = (pkt_valid_out && !transfer) ? ST_DRAIN : ST_STOPPED;
         end
         ST_DRAIN: begin
            if (enable_in)     state_nxt = ST_RUN;
            else if (transfer) state_nxt = ST_STOPPED;
         end
         ST_STOPPED: begin
            if (enable_in) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Single-entry output register; data/dest hold after the packet leaves.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_valid_out <= 1'b0;
         pkt_data_out  <= '0;
         pkt_dest_out  <= '0;
         grant_idx_out <= '0;
         rr_ptr        <= '0;
      end else if (accept) begin
         pkt_valid_out <= 1'b1;
         pkt_data_out  <= win_data;
         pkt_dest_out  <= win_dest;
         grant_idx_out <= win_idx;
         rr_ptr        <= win_next;
      end else if (transfer) begin
         pkt_valid_out <= 1'b0;
      end
   end

`ifdef SOURCE_ARB_STATS_EN
   logic [31:0] stat_cnt [NUM_SRC];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) stat_cnt[i] <= '0;
      end else if (accept) begin
         stat_cnt[win_idx] <= stat_cnt[win_idx] + 32'd1;
      end
   end

   always_comb begin
      stat_count_out = '0;
      if (int'(stat_sel_in) < int'(NUM_SRC)) stat_count_out = stat_cnt[stat_sel_in];
   end
`else
   logic unused_stat_sel;
   assign unused_stat_sel = ^stat_sel_in;
   assign stat_count_out  = '0;
`endif

endmodule

// File: tb/tb_source_arbiter.sv
// Randomized self-checking bench for source_arbiter against a cycle-level
// behavioural model of the arbitration, drain and statistics rules.
module tb_source_arbiter;

   localparam int NS    = 4;
   localparam int DW    = 32;
   localparam int DESTW = 4;
   localparam int IW    = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               enable_in = 1'b1;
   logic [NS*DW-1:0]   req_data_in = '0;
   logic [NS*DESTW-1:0] req_dest_in = '0;
   logic [NS-1:0]      req_valid_in = '0;
   logic [NS-1:0]      req_ready_out;
   logic [DW-1:0]      pkt_data_out;
   logic [DESTW-1:0]   pkt_dest_out;
   logic               pkt_valid_out;
   logic               pkt_ready_in = 1'b0;
   logic [IW-1:0]      grant_idx_out;
   logic [1:0]         state_out;
   logic [IW-1:0]      stat_sel_in = '0;
   logic [31:0]        stat_count_out;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic              m_valid;
   logic [DW-1:0]     m_data;
   logic [DESTW-1:0]  m_dest;
   int                m_idx;
   int                m_ptr;
   int                m_mode;
   int unsigned       m_cnt [NS];
   int                pin_dest2 = -1;

   source_arbiter #(
      .NUM_SRC(NS), .DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .IDX_WIDTH(IW)
   ) dut (
      .clk(clk), .reset(reset), .enable_in(enable_in),
      .req_data_in(req_data_in), .req_dest_in(req_dest_in),
      .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
      .pkt_data_out(pkt_data_out), .pkt_dest_out(pkt_dest_out),
      .pkt_valid_out(pkt_valid_out), .pkt_ready_in(pkt_ready_in),
      .grant_idx_out(grant_idx_out), .state_out(state_out),
      .stat_sel_in(stat_sel_in), .stat_count_out(stat_count_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_pick();
      if (reset || m_mode != 0 || !enable_in || (m_valid && !pkt_ready_in)) return -1;
      for (int k = 0; k < NS; k++) begin
         int i = (m_ptr + k) % NS;
         if (req_valid_in[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] exp_stat();
`ifdef SOURCE_ARB_STATS_EN
      return m_cnt[stat_sel_in];
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_data = '0; m_dest = '0; m_idx = 0; m_ptr = 0; m_mode = 0;
      for (int i = 0; i < NS; i++) m_cnt[i] = 0;
   endtask

   task automatic check_regs();
      chk("pkt_valid", 32'(pkt_valid_out), 32'(m_valid));
      chk("pkt_data", pkt_data_out, m_data);
      chk("pkt_dest", 32'(pkt_dest_out), 32'(m_dest));
      chk("grant_idx", 32'(grant_idx_out), 32'(m_idx));
      chk("state", 32'(state_out), 32'(m_mode));
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input logic en, input logic [NS-1:0] v, input logic rdy);
      int   win;
      logic tr;
      enable_in    = en;
      req_valid_in = v;
      pkt_ready_in = rdy;
      for (int i = 0; i < NS; i++) begin
         req_data_in[i*DW +: DW]       = $urandom;
         req_dest_in[i*DESTW +: DESTW] = DESTW'($urandom);
      end
      if (pin_dest2 >= 0) req_dest_in[2*DESTW +: DESTW] = DESTW'(pin_dest2);
      stat_sel_in = IW'($urandom);
      #1;
      win = model_pick();
      chk("req_ready", 32'(req_ready_out), (win >= 0) ? (32'd1 << win) : 32'd0);
      chk("stat_count", stat_count_out, exp_stat());
      @(posedge clk);
      tr = m_valid && pkt_ready_in;
      case (m_mode)
         0: if (!en) m_mode = (m_valid && !tr) ? 1 : 2;
         1: if (en) m_mode = 0; else if (tr) m_mode = 2;
         default: if (en) m_mode = 0;
      endcase
      if (win >= 0) begin
         m_valid = 1'b1;
         m_data  = req_data_in[win*DW +: DW];
         m_dest  = req_dest_in[win*DESTW +: DESTW];
         m_idx   = win;
         m_ptr   = (win + 1) % NS;
         m_cnt[win]++;
      end else if (tr) begin
         m_valid = 1'b0;
      end
      @(negedge clk);
      check_regs();
   endtask

   // Async reset asserted between clock edges with all sources requesting.
   task automatic do_reset();
      enable_in = 1'b1; req_valid_in = '1; pkt_ready_in = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("rst_valid", 32'(pkt_valid_out), 32'd0);
      chk("rst_ready", 32'(req_ready_out), 32'd0);
      chk("rst_data", pkt_data_out, 32'd0);
      chk("rst_idx", 32'(grant_idx_out), 32'd0);
      chk("rst_state", 32'(state_out), 32'd0);
      chk("rst_stat", stat_count_out, 32'd0);
      @(posedge clk);
      #1 chk("rst_ready_hold", 32'(req_ready_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      model_reset();
      do_reset();

      // All sources valid: strict 0,1,2,3 rotation, valid one cycle after release
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 4'hF, 1'b1);
         chk("rr_seq", 32'(grant_idx_out), 32'(i % 4));
      end

      // Sources 1 and 3 only; pointer now at 2, so 3 comes first
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 4'b1010, 1'b1);
         chk("alt_seq", 32'(grant_idx_out), (i % 2 == 0) ? 32'd3 : 32'd1);
      end

      // Hold source 2 (dest 7) under back-pressure for 5 cycles
      pin_dest2 = 7;
      cycle(1'b1, 4'b0100, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 4'hF, 1'b0);
         chk("bp_idx", 32'(grant_idx_out), 32'd2);
         chk("bp_dest", 32'(pkt_dest_out), 32'd7);
      end
      pin_dest2 = -1;
      cycle(1'b1, 4'hF, 1'b1);
      chk("after_bp", 32'(grant_idx_out), 32'd3);

      // Drain with a held packet, then stop and resume
      cycle(1'b0, 4'hF, 1'b0);
      chk("drain_state", 32'(state_out), 32'd1);
      cycle(1'b0, 4'hF, 1'b0);
      cycle(1'b0, 4'hF, 1'b1);
      chk("stop_state", 32'(state_out), 32'd2);
      chk("stop_valid", 32'(pkt_valid_out), 32'd0);
      cycle(1'b1, 4'hF, 1'b1);
      chk("resume_state", 32'(state_out), 32'd0);
      chk("resume_idle", 32'(pkt_valid_out), 32'd0);
      cycle(1'b1, 4'hF, 1'b1);
      chk("resume_acc", 32'(pkt_valid_out), 32'd1);
      chk("resume_idx", 32'(grant_idx_out), 32'd0);

      // Statistics: 10 from source 0, 3 from source 2
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 4'b0001, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0100, 1'b1);
      stat_sel_in = 2'd0;
      #1;
`ifdef SOURCE_ARB_STATS_EN
      chk("stat_src0", stat_count_out, 32'd10);
`else
      chk("stat_src0", stat_count_out, 32'd0);
`endif
      stat_sel_in = 2'd2;
      #1;
`ifdef SOURCE_ARB_STATS_EN
      chk("stat_src2", stat_count_out, 32'd3);
`else
      chk("stat_src2", stat_count_out, 32'd0);
`endif
      @(negedge clk);

      // Reset mid-stream with a held packet
      cycle(1'b1, 4'hF, 1'b0);
      chk("pre_rst_valid", 32'(pkt_valid_out), 32'd1);
      do_reset();
      cycle(1'b1, 4'b1100, 1'b1);
      chk("post_rst_idx", 32'(grant_idx_out), 32'd2);

      // Randomized traffic, enable toggling and back-pressure
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 9) != 0), NS'($urandom), ($urandom_range(0, 9) < 7));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
